spacewar_frame_sched: RTL and testbench
=======================================

# spacewar_frame_sched

Per-frame scheduler for the Spacewar game core. On each frame tick it walks every object slot (ships, torpedoes) through the single shared physics-update datapath, then drives the shared collision checker through every unordered slot pair, and finally pulses `frame_done`. It sits between the video timing generator, which supplies `frame_tick` at vblank start, and the physics and collision units, which it time-shares.

## Interface
- `N_OBJ`, default 8: number of object slots; legal range 2..16.
- `ID_W`, default `$clog2(N_OBJ)`: slot index width.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse at vblank start
- `enable`  in  1  game running; gates frame start only
- `obj_active`  in  N_OBJ  per-slot live mask
- `clr_overrun`  in  1  clears the sticky overrun flag
- `phys_valid`  out  1  update request to the physics unit
- `phys_id`  out  ID_W  slot being updated
- `phys_ready`  in  1  physics unit accepts the request
- `phys_done`  in  1  physics unit finished the accepted update
- `col_valid`  out  1  pair-check request to the collision unit
- `col_a`, `col_b`  out  ID_W each  pair indices, always a < b
- `col_ready`  in  1  collision unit accepts the pair
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame
- `overrun`  out  1  sticky: a tick arrived while busy

## Operation
- States: IDLE, UPD_ISSUE, UPD_WAIT, COLLIDE, DONE.
- Frame start: IDLE with `frame_tick & enable` moves to UPD_ISSUE. Capture `obj_active` into `act_q` at that edge. Set idx=0. `act_q` is constant for the whole frame.
- UPD_ISSUE:
  - If `act_q[idx]`=0, skip the slot; this costs exactly one cycle.
  - Otherwise assert `phys_valid` with `phys_id`=idx. Both stay stable until `phys_ready`=1. On the handshake, go to UPD_WAIT.
- UPD_WAIT: wait for `phys_done`; it is sampled only in this state.
- Slot advance: after a skip or a `phys_done`, increment idx. After idx=N_OBJ-1, go to COLLIDE with a=0, b=1.
- COLLIDE:
  - If `act_q[a] & act_q[b]`, assert `col_valid` and hold it until `col_ready`.
  - Otherwise skip the pair; this costs one cycle.
  - Advance: b++. If b was N_OBJ-1, then a++ and b=a+1. After pair (N_OBJ-2, N_OBJ-1), go to DONE.
- DONE: `frame_done`=1 for one cycle, then IDLE.
- Overrun: `frame_tick` while not IDLE sets `overrun`; the tick is otherwise ignored and there is no restart. `clr_overrun` clears the flag. If set and clear occur in the same cycle, set wins.
- `enable` low: ticks in IDLE are ignored. A frame already in progress always completes.
- Outputs are decoded from registered state, idx, a, b and `act_q` only. There is no combinational path from any input to any output.

## Timing
- Reset (async, mid-frame included): state=IDLE, idx=a=b=0, `act_q`=0, `overrun`=0. All outputs are 0, `phys_id`/`col_a`/`col_b` are 0, and `col_b` reads 0, not 1.
- Cycle numbering: the tick is sampled at the edge ending cycle 0. Cycle 1 is the first UPD_ISSUE cycle, and `busy` is high from cycle 1.
- Reference frame, N_OBJ=8, all slots active, ready always 1, `phys_done` one cycle after the handshake:
  - each slot takes 2 cycles (cycles 1–16);
  - collision takes 28 cycles (17–44);
  - `frame_done` is high in cycle 45.
- All slots inactive: updates take cycles 1–8, collision cycles 9–36, `frame_done` is high in cycle 37.
- General latency: 1 + N_OBJ + N_OBJ(N_OBJ-1)/2 cycles minimum, plus stalls.
- `busy` drops in the cycle after DONE. A tick in the DONE cycle counts as an overrun.

## Structure
- `spacewar_pkg` holds:
  - the state enum `sched_state_t`;
  - the default `N_OBJ` constant shared with the physics, collision and object RAM blocks.
- Sub-module `spacewar_pair_iter` holds the triangular (a,b) counter, with ports `clr`, `step`, `a`, `b`, `last`. It is reusable by the collision unit's debug port.

## Test plan
- Reset, then a tick with all active and ideal ready/done -> `phys_id` 0..7 in order, all 28 pairs in lexicographic order, `frame_done` in cycle 45 only.
- `obj_active`=8'b0000_0101 -> `phys_valid` only for ids 0 and 2, one `col_valid` with a=0, b=2; `obj_active` changed mid-frame has no effect.
- `phys_ready` held low 5 cycles, `col_ready` toggling -> `phys_id`, `col_a` and `col_b` stable while valid is high; no request dropped or duplicated.
- Second tick at cycle 20, then `clr_overrun` with a simultaneous tick -> `overrun`=1 and stays 1; the frame still ends at cycle 45.
- `rst_n` low during COLLIDE -> all outputs 0 immediately; a fresh tick restarts at `phys_id`=0.
- `enable`=0 with a tick -> no activity, `busy` stays 0.

Source files
------------

// File: rtl/spacewar_pkg.sv
// Shared types and constants for the Spacewar game core blocks.
package spacewar_pkg;

   // Default slot count shared by the physics, collision and object RAM blocks
   localparam int SPACEWAR_N_OBJ = 8;

   typedef enum logic [2:0] {
      IDLE,
      UPD_ISSUE,
      UPD_WAIT,
      COLLIDE,
      DONE
   } sched_state_t;

endpackage

// File: rtl/spacewar_pair_iter.sv
// Triangular (a,b) counter: walks every unordered pair a<b in lexicographic order.
module spacewar_pair_iter #(
   parameter int N_OBJ = 8,
   parameter int ID_W  = $clog2(N_OBJ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            step,
   output logic [ID_W-1:0] a,
   output logic [ID_W-1:0] b,
   output logic            last
);

   localparam logic [ID_W-1:0] LAST_A = ID_W'(N_OBJ - 2);
   localparam logic [ID_W-1:0] LAST_B = ID_W'(N_OBJ - 1);

   // Reset parks at (0,0); clr loads the first real pair (0,1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a <= '0;
         b <= '0;
      end else if (clr) begin
         a <= '0;
         b <= ID_W'(1);
      end else if (step && !last) begin
         if (b == LAST_B) begin
            a <= a + ID_W'(1);
            b <= a + ID_W'(2);
         end else begin
            b <= b + ID_W'(1);
         end
      end
   end

   assign last = (a == LAST_A) && (b == LAST_B);

endmodule

// File: rtl/spacewar_frame_sched.sv
// Per-frame scheduler: physics update for every live slot, then collision check of every live pair.
module spacewar_frame_sched import spacewar_pkg::*; #(
   parameter int N_OBJ = SPACEWAR_N_OBJ,
   parameter int ID_W  = $clog2(N_OBJ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             enable,
   input  logic [N_OBJ-1:0] obj_active,
   input  logic             clr_overrun,
   output logic             phys_valid,
   output logic [ID_W-1:0]  phys_id,
   input  logic             phys_ready,
   input  logic             phys_done,
   output logic             col_valid,
   output logic [ID_W-1:0]  col_a,
   output logic [ID_W-1:0]  col_b,
   input  logic             col_ready,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
);

   localparam logic [ID_W-1:0] IDX_LAST = ID_W'(N_OBJ - 1);

   sched_state_t     state, state_nxt;
   logic [ID_W-1:0]  idx, idx_nxt;
   logic [N_OBJ-1:0] act_q;
   logic [ID_W-1:0]  pa, pb;
   logic             pair_last, pair_clr, pair_step;
   logic             start, slot_adv, pair_live;

   assign start     = (state == IDLE) && frame_tick && enable;
   assign pair_live = act_q[pa] && act_q[pb];

   spacewar_pair_iter #(.N_OBJ(N_OBJ), .ID_W(ID_W)) u_pair_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pair_clr),
      .step  (pair_step),
      .a     (pa),
      .b     (pb),
      .last  (pair_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         act_q <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (start) act_q <= obj_active;
      end
   end

   // Set has priority so a late tick is never lost to a concurrent clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           overrun <= 1'b0;
      else if (frame_tick && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)                 overrun <= 1'b0;
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      pair_clr  = 1'b0;
      pair_step = 1'b0;
      slot_adv  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = UPD_ISSUE;
               idx_nxt   = '0;
               pair_clr  = 1'b1;
            end
         end
         UPD_ISSUE: begin
            if (!act_q[idx])     slot_adv  = 1'b1;
            else if (phys_ready) state_nxt = UPD_WAIT;
         end
         UPD_WAIT: begin
            if (phys_done) slot_adv = 1'b1;
         end
         COLLIDE: begin
            if (!pair_live || col_ready) begin
               if (pair_last) state_nxt = DONE;
               else           pair_step = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (slot_adv) begin
         if (idx == IDX_LAST) begin
            state_nxt = COLLIDE;
            idx_nxt   = '0;
         end else begin
            state_nxt = UPD_ISSUE;
            idx_nxt   = idx + ID_W'(1);
         end
      end
   end

   assign phys_valid = (state == UPD_ISSUE) && act_q[idx];
   assign phys_id    = idx;
   assign col_valid  = (state == COLLIDE) && pair_live;
   assign col_a      = pa;
   assign col_b      = pb;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_spacewar_frame_sched.sv
// Randomized self-checking bench: transaction scoreboard plus frame-latency model.
module tb_spacewar_frame_sched;

   localparam int N     = 8;
   localparam int IW    = 3;
   localparam int NPAIR = N * (N - 1) / 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_tick, enable, clr_overrun;
   logic [N-1:0]  obj_active;
   logic          phys_valid, phys_ready, phys_done;
   logic [IW-1:0] phys_id;
   logic          col_valid, col_ready;
   logic [IW-1:0] col_a, col_b;
   logic          busy, frame_done, overrun;

   int n_chk  = 0;
   int n_pass = 0;
   bit ovr_m  = 1'b0;

   spacewar_frame_sched #(.N_OBJ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .enable      (enable),
      .obj_active  (obj_active),
      .clr_overrun (clr_overrun),
      .phys_valid  (phys_valid),
      .phys_id     (phys_id),
      .phys_ready  (phys_ready),
      .phys_done   (phys_done),
      .col_valid   (col_valid),
      .col_a       (col_a),
      .col_b       (col_b),
      .col_ready   (col_ready),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int outs_word();
      return int'({phys_valid, phys_id, col_valid, col_a, col_b, busy, frame_done, overrun});
   endfunction

   // One frame; stall randomizes ready/done, inj_cyc injects a tick, rst_cyc aborts with reset.
   task automatic run_frame(input logic [N-1:0] mask, input bit stall,
                            input int inj_cyc, input bit inj_clr, input int rst_cyc);
      int exp_ids[$];
      int exp_pairs[$];
      int cyc = 0, stalls = 0, done_cyc = 0, n_act = 0, done_at = -1, e;
      bit pv_q = 0, pr_q = 0, cv_q = 0, cr_q = 0, aborted = 0;
      int pid_q = 0, pair_q = 0;
      for (int i = 0; i < N; i++) if (mask[i]) begin exp_ids.push_back(i); n_act++; end
      for (int a = 0; a < N; a++)
         for (int b = a + 1; b < N; b++)
            if (mask[a] && mask[b]) exp_pairs.push_back(a * 16 + b);

      @(negedge clk);
      obj_active = mask; frame_tick = 1'b1; enable = 1'b1;
      phys_ready = 1'b0; col_ready = 1'b0; phys_done = 1'b0; clr_overrun = 1'b0;
      while (done_cyc == 0) begin
         @(negedge clk);
         cyc++;
         frame_tick = 1'b0; clr_overrun = 1'b0; phys_done = 1'b0;
         obj_active = N'($urandom);
         if (cyc == rst_cyc) begin
            rst_n = 1'b0;
            #1 chk("rst_async_outs", outs_word(), 0);
            ovr_m = 1'b0; aborted = 1'b1;
            @(negedge clk);
            chk("rst_hold_outs", outs_word(), 0);
            rst_n = 1'b1;
            break;
         end
         if (pv_q && !pr_q) chk("phys_hold", int'({phys_valid, phys_id}), 8 + pid_q);
         if (cv_q && !cr_q) chk("col_hold", int'(col_valid) * 256 + int'(col_a) * 16 + int'(col_b), 256 + pair_q);
         if (frame_done) done_cyc = cyc;
         phys_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         col_ready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (done_at == cyc) phys_done = 1'b1;
         if (phys_valid && phys_ready) begin
            e = (exp_ids.size() > 0) ? exp_ids.pop_front() : -1;
            chk("phys_id", int'(phys_id), e);
            done_at = cyc + (stall ? int'($urandom_range(1, 3)) : 1);
            stalls += done_at - cyc - 1;
         end else if (phys_valid) stalls++;
         if (col_valid && col_ready) begin
            e = (exp_pairs.size() > 0) ? exp_pairs.pop_front() : -1;
            chk("col_pair", int'(col_a) * 16 + int'(col_b), e);
         end else if (col_valid) stalls++;
         if (cyc == inj_cyc) begin
            frame_tick = 1'b1; clr_overrun = inj_clr; ovr_m = 1'b1;
         end
         pv_q = phys_valid; pr_q = phys_ready; pid_q = int'(phys_id);
         cv_q = col_valid;  cr_q = col_ready;  pair_q = int'(col_a) * 16 + int'(col_b);
         if (cyc > 3000) begin
            chk("frame_timeout", 1, 0);
            break;
         end
      end
      if (!aborted) begin
         chk("done_cycle", done_cyc, N + n_act + NPAIR + 1 + stalls);
         chk("phys_left", exp_ids.size(), 0);
         chk("pairs_left", exp_pairs.size(), 0);
         @(negedge clk);
         frame_tick = 1'b0; clr_overrun = 1'b0; phys_done = 1'b0;
         chk("idle_after_done", int'({busy, frame_done}), 0);
         chk("overrun", int'(overrun), int'(ovr_m));
      end
   endtask

   task automatic clear_ovr();
      @(negedge clk); clr_overrun = 1'b1;
      @(negedge clk); clr_overrun = 1'b0; ovr_m = 1'b0;
      chk("overrun_cleared", int'(overrun), 0);
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; clr_overrun = 1'b0;
      obj_active = '0; phys_ready = 1'b0; phys_done = 1'b0; col_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs_word(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_outs", outs_word(), 0);

      run_frame(8'hFF, 0, 0, 0, 0);          // reference: done in cycle 45
      run_frame(8'h00, 0, 0, 0, 0);          // done in cycle 37
      run_frame(8'b0000_0101, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) run_frame(N'($urandom), 1, 0, 0, 0);

      run_frame(8'hFF, 0, 20, 0, 0);         // late tick sets overrun, frame still ends at 45
      run_frame(8'hFF, 0, 30, 1, 0);         // set beats simultaneous clear
      clear_ovr();
      run_frame(8'h00, 0, 37, 0, 0);         // tick in the DONE cycle
      clear_ovr();

      run_frame(8'hFF, 0, 0, 0, 25);         // reset during COLLIDE
      run_frame(N'($urandom) | 8'h01, 0, 0, 0, 0);

      @(negedge clk); enable = 1'b0; frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("disabled_idle", int'({busy, phys_valid, col_valid}), 0);
         @(negedge clk);
      end
      enable = 1'b1;
      run_frame(N'($urandom), 1, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
